muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage, alongside the ALU. It takes the same two register operands the ALU receives. It runs a radix-2 shift-add multiply or a restoring divide over 32 cycles and returns a 32-bit result to the writeback mux next to `alu_out`. Hazard control holds the pipeline while `busy` is high.

## Interface
- `WIDTH`, 32, operand/result width; only 32 is supported.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high; clears all state
- `start`  in  1  request; sampled only when `busy`=0
- `op`  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `a`  in  WIDTH  rs1 operand (multiplicand/dividend), latched at accept
- `b`  in  WIDTH  rs2 operand (multiplier/divisor), latched at accept
- `busy`  out  1  high while in CALC
- `done`  out  1  one-cycle pulse; `result` valid in that cycle
- `result`  out  WIDTH  last completed result; held until next completion

## Operation
- States: IDLE, CALC, DONE. The reset state is IDLE.
- IDLE or DONE with `start`=1:
  - Latch `op`, the operand magnitudes and the sign flags.
  - Clear `count`.
  - Go to CALC. If a special case applies, go to DONE instead.
- IDLE or DONE with `start`=0: go to or stay in IDLE.
- CALC: perform one iteration per edge. `count` is 5 bits. After iteration 31, go to DONE.
- DONE: `done`=1 and `result` is updated. A new `start` is accepted in this state, which gives back-to-back operation.
- `start` while in CALC is ignored; there is no queueing.
- Signedness:
  - `a` is treated as signed for MULH, MULHSU, DIV and REM.
  - `b` is treated as signed for MULH, DIV and REM.
  - MUL low word is sign-agnostic.
  - Signed operands are converted to magnitudes. Iteration is unsigned.
- Sign fix-up:
  - Product is negated when sign_a^sign_b.
  - Quotient is negated when sign_a^sign_b.
  - Remainder takes the sign of the dividend.
- Multiply: 64-bit accumulator. MUL returns [31:0]; MULH, MULHSU and MULHU return [63:32].
- Divide: restoring algorithm with a 33-bit partial remainder, one quotient bit per iteration.
- Special cases go IDLE/DONE→DONE directly, with no CALC:
  - Divisor 0: DIV/DIVU return 32'hFFFF_FFFF; REM/REMU return `a`.
  - Signed overflow (a=32'h8000_0000, b=32'hFFFF_FFFF) for DIV returns 32'h8000_0000; for REM returns 0.
- Reset mid-operation: return to IDLE; `busy`=0, `done`=0, `result`=0. The partial computation is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, state IDLE.
- All outputs are registered. There is no combinational path from `start`, `a` or `b` to any output.
- Accept edge E0 is the edge sampling `start`=1.
  - `busy` rises after E0.
  - Iterations occur at E1..E32.
  - State becomes DONE at E32.
  - `busy` falls after E32.
  - `done` is high for the one cycle between E32 and E33.
- Normal latency: `done` appears 33 cycles after the `start` cycle.
- Special-case latency: `done` is high in the cycle right after E0, and `busy` never asserts.
- `a`, `b` and `op` may change freely after E0.
- `result` changes only at the edge that enters DONE.

## Structure
- Shared package `muldiv_pkg` holds:
  - the op localparams: OP_MUL … OP_REMU, matching funct3;
  - the state encoding for IDLE/CALC/DONE;
  - the division special-case constants: all-ones quotient, INT_MIN.
- The package is shared with the decoder and hazard unit, so funct3 decoding is not duplicated.
- Sub-module `sign_fix`: a combinational conditional negate, `in`, `neg` → `out`. It is instantiated for operand magnitudes and for result fix-up.
- Everything else lives in one always block for the FSM and datapath, plus output registers.

## Test plan
- MUL 7×(-3): a=7, b=32'hFFFF_FFFD, `start` at E0.
  - Requires `busy` for 32 cycles.
  - Requires a `done` pulse at cycle 33 with `result`=32'hFFFF_FFEB.
- MULH/MULHSU/MULHU, with a=b=32'h8000_0000:
  - MULH → 32'h4000_0000
  - MULHSU → 32'hC000_0000
  - MULHU → 32'h4000_0000
- DIV/REM, with a=-7 (32'hFFFF_FFF9), b=2:
  - DIV → 32'hFFFF_FFFD
  - REM → 32'hFFFF_FFFF
  - DIVU with a=7, b=2 → 3
  - REMU with a=7, b=2 → 1
- Special cases:
  - DIVU 5/0 → 32'hFFFF_FFFF
  - REM 5/0 → 5
  - DIV 32'h8000_0000/32'hFFFF_FFFF → 32'h8000_0000
  - REM of the same operands → 0
  - Every special case requires `done` one cycle after `start`, with `busy` never high.
- Handshake:
  - `start` pulsed during CALC with different operands is ignored, and the first result is unchanged.
  - `start` asserted in the DONE cycle is accepted, and a second `done` pulse follows 33 cycles later.
- Reset mid-operation: assert `reset` at cycle 10 of CALC, asynchronously off-edge.
  - Requires `busy`, `done` and `result` at 0 immediately.
  - Requires no `done` pulse afterwards.
  - A subsequent MUL 3×4 must return 12.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: definitions shared by the RV32M multiply/divide unit, the
// decoder and the hazard unit.
//   - OP_* : RV32M funct3 encodings
//   - state_t : IDLE / CALC / DONE encoding of the iterative unit
//   - DIV_ALL_ONES, INT_MIN : division special-case results
//   - op_* helpers : operand signedness and op class derived from funct3
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [31:0] DIV_ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN      = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // rs1 is signed for MULH, MULHSU, DIV and REM.
    function automatic logic op_a_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 is signed for MULH, DIV and REM.
    function automatic logic op_b_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // Signed division ops, the only ones that can overflow.
    function automatic logic op_signed_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the execute stage and the
// multiply/divide unit.
//   start, op, a, b : request (master -> slave)
//   busy, done, result : status and result (slave -> master)
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, a, b,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_sign_fix.sv
// sign_fix: combinational conditional two's-complement negate.
//   in  : value
//   neg : 1 -> out = -in, 0 -> out = in
//   out : result
module sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in,
    input  logic             neg,
    output logic [WIDTH-1:0] out
);
    assign out = neg ? (~in + WIDTH'(1)) : in;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (32 iterations).
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, clears all state
//   bus   : muldiv_if slave (start/op/a/b in; busy/done/result out)
// Multiply is radix-2 shift-add on operand magnitudes; divide is restoring
// division on magnitudes. Signs are re-applied on the final iteration so the
// result register is written at the edge that enters DONE.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);

    state_t                 state_q, state_d;
    logic [2:0]             op_q, op_d;
    logic [WIDTH-1:0]       mag_a_q, mag_a_d;
    logic [WIDTH-1:0]       mag_b_q, mag_b_d;
    logic                   sign_a_q, sign_a_d;
    logic                   sign_b_q, sign_b_d;
    logic [4:0]             count_q, count_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]       rem_q, rem_d;
    logic [WIDTH-1:0]       quo_q, quo_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [WIDTH-1:0]       result_q, result_d;

    // Operand magnitudes at accept.
    logic                   in_sign_a, in_sign_b;
    logic [WIDTH-1:0]       in_mag_a, in_mag_b;

    assign in_sign_a = op_a_signed(bus.op) & bus.a[WIDTH-1];
    assign in_sign_b = op_b_signed(bus.op) & bus.b[WIDTH-1];

    sign_fix #(.WIDTH(WIDTH)) u_mag_a (.in(bus.a), .neg(in_sign_a), .out(in_mag_a));
    sign_fix #(.WIDTH(WIDTH)) u_mag_b (.in(bus.b), .neg(in_sign_b), .out(in_mag_b));

    // Special cases resolved at accept without iterating.
    logic                   in_div_zero, in_ovf;
    logic [WIDTH-1:0]       special_result;

    assign in_div_zero    = bus.op[2] && (bus.b == '0);
    assign in_ovf         = op_signed_div(bus.op) && (bus.a == INT_MIN) && (bus.b == DIV_ALL_ONES);
    assign special_result = in_div_zero ? (bus.op[1] ? bus.a : DIV_ALL_ONES)
                                        : (bus.op[1] ? '0 : INT_MIN);

    // Multiply step: acc holds {partial product high, remaining multiplier}.
    // The 33-bit sum keeps the carry, which shifts into the top bit.
    logic [WIDTH:0]         mul_sum;
    logic [2*WIDTH-1:0]     mul_next;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide step: dividend bits shift out of quo_q into the
    // 33-bit partial remainder while quotient bits shift in.
    logic [WIDTH:0]         div_shift, div_diff;
    logic                   div_fits;
    logic [WIDTH-1:0]       rem_next, quo_next;

    assign div_shift = {rem_q, quo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mag_b_q};
    assign div_fits  = ~div_diff[WIDTH];
    assign rem_next  = div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign quo_next  = {quo_q[WIDTH-2:0], div_fits};

    // Sign fix-up of the final-iteration values. Remainder follows the
    // dividend; product and quotient follow sign_a ^ sign_b.
    logic [2*WIDTH-1:0]     prod_fixed;
    logic [WIDTH-1:0]       div_raw, div_fixed, calc_result;
    logic                   div_neg;

    assign div_raw = op_q[1] ? rem_next : quo_next;
    assign div_neg = op_q[1] ? sign_a_q : (sign_a_q ^ sign_b_q);

    sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (.in(mul_next), .neg(sign_a_q ^ sign_b_q), .out(prod_fixed));
    sign_fix #(.WIDTH(WIDTH))   u_fix_div  (.in(div_raw), .neg(div_neg), .out(div_fixed));

    assign calc_result = op_q[2]           ? div_fixed :
                         (op_q == OP_MUL)  ? prod_fixed[WIDTH-1:0] :
                                             prod_fixed[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        count_d  = count_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    op_d     = bus.op;
                    mag_a_d  = in_mag_a;
                    mag_b_d  = in_mag_b;
                    sign_a_d = in_sign_a;
                    sign_b_d = in_sign_b;
                    count_d  = '0;
                    acc_d    = {{WIDTH{1'b0}}, in_mag_b};
                    rem_d    = '0;
                    quo_d    = in_mag_a;
                    if (in_div_zero || in_ovf) begin
                        state_d  = ST_DONE;
                        result_d = special_result;
                    end else begin
                        state_d  = ST_CALC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                // Both datapaths step every cycle; op_q selects the result.
                acc_d   = mul_next;
                rem_d   = rem_next;
                quo_d   = quo_next;
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    state_d  = ST_DONE;
                    result_d = calc_result;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_CALC);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            count_q  <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit. Directed vectors,
// handshake and reset scenarios, then randomized operations compared with a
// plain-arithmetic reference model.
module tb_muldiv_unit;

    localparam logic [2:0] T_MUL = 3'd0, T_MULH = 3'd1, T_MULHSU = 3'd2, T_MULHU = 3'd3;
    localparam logic [2:0] T_DIV = 3'd4, T_DIVU = 3'd5, T_REM = 3'd6, T_REMU = 3'd7;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_exp = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: RV32M semantics with 64-bit integer arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        case (op)
            T_MUL:    begin p = ua * ub; return p[31:0];  end
            T_MULH:   begin p = sa * sb; return p[63:32]; end
            T_MULHSU: begin p = sa * ub; return p[63:32]; end
            T_MULHU:  begin p = ua * ub; return p[63:32]; end
            T_DIV:    begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            T_DIVU:   begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            T_REM:    begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default:  begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && b == 0) return 1'b1;
        return ((op == T_DIV) || (op == T_REM)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Drive a request; the caller is at a negedge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
    endtask

    // Follow an issued request until done; returns at the negedge where done is seen.
    task automatic finish(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag, input bit pulse_mid);
        int lat = 0;
        int busy_cnt = 0;
        bit seen = 1'b0;
        bit spc;
        spc = is_special(op, a, b);
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.start = 1'b0;
                bus.op    = 3'($urandom);
                bus.a     = $urandom;
                bus.b     = $urandom;
                if (!spc) check({tag, ".hold"}, bus.result, last_exp);
            end
            if (pulse_mid && k == 10) begin
                bus.start = 1'b1;
                bus.op    = 3'($urandom);
                bus.a     = $urandom;
                bus.b     = $urandom;
            end
            if (pulse_mid && k == 11) bus.start = 1'b0;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        check({tag, ".latency"}, 32'(lat), spc ? 32'd1 : 32'd33);
        check({tag, ".busy_cycles"}, 32'(busy_cnt), spc ? 32'd0 : 32'd32);
        check({tag, ".result"}, bus.result, exp);
        $display("op=%0d a=%h b=%h result=%h expected=%h latency=%0d", op, a, b, bus.result, exp, lat);
        last_exp = exp;
    endtask

    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string tag, input bit pulse_mid);
        @(negedge clk);
        issue(op, a, b);
        finish(op, a, b, exp, tag, pulse_mid);
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int done_seen;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        #12;
        check("reset.busy",   32'(bus.busy), 32'd0);
        check("reset.done",   32'(bus.done), 32'd0);
        check("reset.result", bus.result,    32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors.
        run(T_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7x-3", 1'b0);
        run(T_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, "mulh",     1'b0);
        run(T_MULHSU, 32'h8000_0000,  32'h8000_0000, 32'hC000_0000, "mulhsu",   1'b0);
        run(T_MULHU,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000, "mulhu",    1'b0);
        run(T_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "div",      1'b0);
        run(T_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "rem",      1'b0);
        run(T_DIVU,   32'd7,          32'd2,         32'd3,         "divu",     1'b0);
        run(T_REMU,   32'd7,          32'd2,         32'd1,         "remu",     1'b0);
        run(T_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, "divu_by0", 1'b0);
        run(T_REM,    32'd5,          32'd0,         32'd5,         "rem_by0",  1'b0);
        run(T_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "div_ovf",  1'b0);
        run(T_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         "rem_ovf",  1'b0);

        // start during CALC is ignored.
        run(T_DIV, 32'd1000, 32'd7, 32'd142, "ignore_mid", 1'b1);

        // Back-to-back: start asserted in the DONE cycle.
        @(negedge clk);
        issue(T_MUL, 32'd9, 32'd11);
        finish(T_MUL, 32'd9, 32'd11, 32'd99, "b2b_first", 1'b0);
        issue(T_DIVU, 32'd100, 32'd7);
        finish(T_DIVU, 32'd100, 32'd7, 32'd14, "b2b_second", 1'b0);
        @(negedge clk);
        check("b2b.done_pulse", 32'(bus.done), 32'd0);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        issue(T_MUL, 32'd5, 32'd6);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
        end
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid.busy",   32'(bus.busy), 32'd0);
        check("rst_mid.done",   32'(bus.done), 32'd0);
        check("rst_mid.result", bus.result,    32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        check("rst_mid.no_done", 32'(done_seen), 32'd0);
        last_exp = '0;
        run(T_MUL, 32'd3, 32'd4, 32'd12, "mul_after_rst", 1'b0);

        // Randomized operations against the reference model.
        for (int n = 0; n < 50; n++) begin
            rop = 3'($urandom);
            ra  = pick_operand();
            rb  = pick_operand();
            run(rop, ra, rb, model(rop, ra, rb), "rand", 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
